fa_dff_cell: RTL and testbench
==============================

// Module: fa_dff_cell
// PURPOSE
// - Primitive cell bank for the radix-2 serial online adder datapath.
// - Two independent sub-functions, each vectorised over WIDTH lanes:
//   - a bit-wise 3-input full adder (combinational);
//   - an enable-gated D flip-flop register (sequential).
// - The online adder instantiates these cells for its digit-serial pipeline:
//   - FA stages;
//   - digit-delay registers, stalled by a global enable during rest cycles.
// PARAMETERS
// - WIDTH      1     number of independent lanes in each sub-function (>=1)
// - RESET_VAL  1'b0  value loaded into every q bit on reset
// PORTS
// - clk         in   1      rising-edge clock for the register bank
// - asyn_reset  in   1      reset, asynchronous, active-high; clears q
// - en          in   1      register enable; 1 = load d, 0 = hold q
// - d           in   WIDTH  register data input
// - q           out  WIDTH  register output
// - a           in   WIDTH  full-adder operand A
// - b           in   WIDTH  full-adder operand B
// - cin         in   WIDTH  full-adder carry-in
// - carry       out  WIDTH  full-adder carry-out (weight 2)
// - sum         out  WIDTH  full-adder sum (weight 1)
// BEHAVIOUR
// - Reset is asyn_reset: asynchronous, active-high. Clock is clk.
// Full adder (purely combinational, zero latency, per lane i):
// - a[i] + b[i] + cin[i] = 2*carry[i] + sum[i]
// - sum[i]   = a[i] ^ b[i] ^ cin[i]
// - carry[i] = majority(a[i], b[i], cin[i])
// - Outputs are unaffected by clk, en and asyn_reset.
// - No X-propagation masking: X on an input may give X on the output.
// Register (per lane i):
// - asyn_reset high: q <= {WIDTH{RESET_VAL}} immediately, without waiting for
//   a clock edge.
// - While asyn_reset is high, q stays at the reset value regardless of clk/en.
// - Release of asyn_reset takes no effect until the next rising clk edge.
// - At a rising clk edge with asyn_reset low:
//   - en==1: q <= d (latency 1 cycle);
//   - en==0: q holds its current value.
// - en is sampled only at the clk edge; en changes between edges are ignored.
// - Reset wins over a simultaneous clock edge with en==1.
// - Lanes are fully independent; no carry chains between lanes.
// - The register has no output combinational path from d or en.
// TESTING
// - FA exhaustive check: all 8 (a,b,cin) combinations, WIDTH=1.
//   - 0,0,0 -> carry=0, sum=0
//   - 1,0,1 -> carry=1, sum=0
//   - 1,1,1 -> carry=1, sum=1
//   - 0,1,0 -> carry=0, sum=1
// - Register load: en=1, d=1 at edge N -> q==1 after edge N; d=0 at N+1 -> q==0.
// - Register hold: q==1, en=0, d toggled 0/1 for 5 edges -> q stays 1;
//   en=1 on the next edge with d=0 -> q==0.
// - Asynchronous reset:
//   - q==1, pulse asyn_reset mid-cycle -> q==0 before the next edge;
//   - edge during reset with en=1, d=1 -> q stays 0;
//   - first edge after release loads d.
// - Multi-lane (WIDTH=4):
//   - a=4'b1100, b=4'b1010, cin=4'b0110 -> sum=4'b0000, carry=4'b1110;
//   - en=1, d=4'hA -> q=4'hA after one edge.
// - Pipeline stall: en pattern 1,1,0,0,1 with d=1,0,1,1,1 -> q after each edge
//   is 1,0,0,0,1.

Source files
------------

// File: rtl/fa_dff_cell.sv
// Primitive cell bank for the radix-2 serial online adder: WIDTH independent
// full adders plus WIDTH enable-gated D flip-flops sharing one clock and reset.
module fa_dff_cell #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             asyn_reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] cin,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Bit-wise operators keep every lane independent: no carry crosses lanes.
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

    // NOTE: the hold path is an explicit mux in always_comb so the enable gates data, never the clock.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            q_q <= {WIDTH{RESET_VAL}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_fa_dff_cell.sv
// Directed scoreboard bench for fa_dff_cell: exhaustive 1-lane full adder,
// register load/hold/async reset/stall, and a 4-lane instance.
module tb_fa_dff_cell;

    logic       clk = 1'b0;
    logic       asyn_reset;
    logic       en;
    logic [0:0] d1, q1, a1, b1, cin1, carry1, sum1;
    logic [3:0] d4, q4, a4, b4, cin4, carry4, sum4;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    fa_dff_cell #(.WIDTH(1)) dut1 (
        .clk(clk), .asyn_reset(asyn_reset), .en(en), .d(d1), .q(q1),
        .a(a1), .b(b1), .cin(cin1), .carry(carry1), .sum(sum1)
    );

    fa_dff_cell #(.WIDTH(4)) dut4 (
        .clk(clk), .asyn_reset(asyn_reset), .en(en), .d(d4), .q(q4),
        .a(a4), .b(b4), .cin(cin4), .carry(carry4), .sum(sum4)
    );

    task automatic expect_val(input string tag, input logic [3:0] value);
        tag_q.push_back(tag);
        exp_q.push_back(value);
    endtask

    task automatic check(input logic [3:0] observed);
        logic [3:0] expected;
        string      tag;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed %h, required a queued expectation", observed);
            return;
        end
        expected = exp_q.pop_front();
        tag      = tag_q.pop_front();
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] total;
        logic [0:0] model_q;
        logic [4:0] en_pat;
        logic [4:0] d_pat;

        asyn_reset = 1'b1;
        en = 1'b0;
        d1 = '0; d4 = '0;
        a1 = '0; b1 = '0; cin1 = '0;
        a4 = '0; b4 = '0; cin4 = '0;

        #2;
        expect_val("reset_q1", 4'h0);
        check({3'b000, q1});
        expect_val("reset_q4", 4'h0);
        check(q4);

        tick();
        tick();
        asyn_reset = 1'b0;

        // Full adder, all eight input combinations.
        for (int v = 0; v < 8; v++) begin
            a1   = 1'(v >> 2);
            b1   = 1'(v >> 1);
            cin1 = 1'(v);
            total = 2'(a1) + 2'(b1) + 2'(cin1);
            expect_val($sformatf("fa1_%0d", v), {2'b00, total});
            #1;
            check({2'b00, carry1, sum1});
        end

        a4 = 4'b1100; b4 = 4'b1010; cin4 = 4'b0110;
        expect_val("fa4_sum", 4'b0000);
        expect_val("fa4_carry", 4'b1110);
        #1;
        check(sum4);
        check(carry4);

        // Register load.
        en = 1'b1; d1 = 1'b1;
        expect_val("load_1", 4'h1);
        tick();
        check({3'b000, q1});
        d1 = 1'b0;
        expect_val("load_0", 4'h0);
        tick();
        check({3'b000, q1});

        // Register hold while d toggles.
        d1 = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d1 = 1'(i);
            expect_val($sformatf("hold_%0d", i), 4'h1);
            tick();
            check({3'b000, q1});
        end
        en = 1'b1; d1 = 1'b0;
        expect_val("hold_release", 4'h0);
        tick();
        check({3'b000, q1});

        // en pulsed only between edges must be ignored.
        d1 = 1'b1;
        tick();
        en = 1'b0; d1 = 1'b0;
        #2 en = 1'b1;
        #1 en = 1'b0;
        expect_val("en_glitch", 4'h1);
        tick();
        check({3'b000, q1});

        // Asynchronous reset mid-cycle, with the adder still live.
        #2 asyn_reset = 1'b1;
        en = 1'b1; d1 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        expect_val("async_clear", 4'h0);
        expect_val("fa_during_reset", 4'b0010);
        #1;
        check({3'b000, q1});
        check({2'b00, carry1, sum1});
        expect_val("reset_beats_edge", 4'h0);
        tick();
        check({3'b000, q1});
        #2 asyn_reset = 1'b0;
        expect_val("released_no_edge", 4'h0);
        #1;
        check({3'b000, q1});
        expect_val("first_edge_after_release", 4'h1);
        tick();
        check({3'b000, q1});

        // Multi-lane register.
        d4 = 4'hA;
        expect_val("q4_load", 4'hA);
        tick();
        check(q4);

        // Pipeline stall pattern, expectations from a reference model.
        en = 1'b1; d1 = 1'b0;
        tick();
        model_q = 1'b0;
        en_pat  = 5'b10011;
        d_pat   = 5'b11101;
        for (int i = 0; i < 5; i++) begin
            en = en_pat[i];
            d1 = d_pat[i];
            if (en) model_q = d1;
            expect_val($sformatf("stall_%0d", i), {3'b000, model_q});
            tick();
            check({3'b000, q1});
        end

        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_leftover: %0d expectations unconsumed, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
